// File: rtl/barrel_shift_pipe_if.sv
// rtl/barrel_shift_pipe_if.sv - operand/shift-control/result bundle for the pipelined barrel shifter
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int SW    = 5
);
    logic [WIDTH-1:0] I;
    logic [SW-1:0]    S;
    logic             R;
    logic [WIDTH-1:0] O;

    modport master (output I, output S, output R, input O);
    modport slave  (input I, input S, input R, output O);
endinterface

// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - 32-bit logical barrel shifter, one register stage per shift-amount bit
module barrel_shift_pipe #(
    parameter int WIDTH = 32,
    parameter int SW    = 5
) (
    input  logic                clk,
    input  logic                reset,
    barrel_shift_pipe_if.slave  io
);

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int AMT = 1 << k;

        logic [WIDTH-1:0] din;
        logic             rin;
        logic [SW-1-k:0]  sin;
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;

        // sin[0] is the shift bit this stage consumes; the rest travel onward
        if (k == 0) begin : g_in
            assign din = io.I;
            assign rin = io.R;
            assign sin = io.S;
        end else begin : g_in
            assign din = g_stage[k-1].data_q;
            assign rin = g_stage[k-1].g_carry.r_q;
            assign sin = g_stage[k-1].g_carry.s_q;
        end

        always_comb begin
            data_d = din;
            if (sin[0]) begin
                data_d = rin ? (din >> AMT) : (din << AMT);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        // The final stage has no downstream consumer for direction or shift bits
        if (k < SW - 1) begin : g_carry
            logic            r_d;
            logic            r_q;
            logic [SW-2-k:0] s_d;
            logic [SW-2-k:0] s_q;

            always_comb begin
                r_d = rin;
                s_d = sin[SW-1-k:1];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= 1'b0;
                    s_q <= '0;
                end else begin
                    r_q <= r_d;
                    s_q <= s_d;
                end
            end
        end
    end

    assign io.O = g_stage[SW-1].data_q;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - randomized and directed checks of barrel_shift_pipe against a latency-queue model
module tb_barrel_shift_pipe;
    localparam int WIDTH = 32;
    localparam int SW    = 5;
    localparam int LAT   = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.WIDTH(WIDTH), .SW(SW)) bus ();

    barrel_shift_pipe #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] pipe[$];

    logic [WIDTH-1:0] d_i   [7] = '{32'd10, 32'd63, 32'hDEADBEEF, 32'hDEADBEEF,
                                    32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    logic [SW-1:0]    d_s   [7] = '{5'd2, 5'd5, 5'd0, 5'd0, 5'd31, 5'd31, 5'd16};
    logic             d_r   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] d_exp [7] = '{32'h00000002, 32'h000007E0, 32'hDEADBEEF, 32'hDEADBEEF,
                                    32'h00000001, 32'h80000000, 32'h0000FFFF};

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] i, input logic [SW-1:0] s, input logic r);
        return r ? (i >> s) : (i << s);
    endfunction

    task automatic drive(input logic [WIDTH-1:0] i, input logic [SW-1:0] s, input logic r);
        bus.I = i;
        bus.S = s;
        bus.R = r;
    endtask

    task automatic drive_rand();
        drive($urandom, SW'($urandom_range(WIDTH - 1, 0)), 1'($urandom_range(1, 0)));
    endtask

    // One clock: advance the model on the same edge the DUT samples, then compare
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) begin
            pipe = {};
            repeat (LAT) pipe.push_back('0);
        end else begin
            pipe.push_back(ref_shift(bus.I, bus.S, bus.R));
            void'(pipe.pop_front());
        end
        #1;
        check(tag, bus.O, pipe[0]);
    endtask

    initial begin
        reset = 1'b1;
        drive($urandom, SW'($urandom), 1'b1);
        repeat (2) begin
            step("reset_model");
            check("reset_zero", bus.O, '0);
        end
        reset = 1'b0;

        for (int k = 0; k < 7 + 4; k++) begin
            if (k < 7) drive(d_i[k], d_s[k], d_r[k]);
            else       drive('0, '0, 1'b0);
            step("directed_model");
            if (k >= 4) check("directed_const", bus.O, d_exp[k-4]);
            else        check("latency_zero", bus.O, '0);
        end

        for (int k = 0; k < 5; k++) begin
            drive_rand();
            step("prereset_model");
        end
        reset = 1'b1;
        drive_rand();
        step("midreset_model");
        check("midreset_zero", bus.O, '0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_rand();
            step("postreset_model");
            check("no_stale", bus.O, '0);
        end

        for (int k = 0; k < 1000; k++) begin
            drive_rand();
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
- Fully pipelined 32-bit logical barrel shifter with one pipeline stage per shift-amount bit (5 stages).
- Accepts a new operand, shift amount and direction every clock cycle.
- Delivers the registered result a fixed 5 cycles later.
- Datapath utility block for ALU/shift units that need high clock rate at fixed latency.

Parameters:
- WIDTH, 32, data width in bits; must equal 2**SW.
- SW, 5, shift-amount width; also the number of pipeline stages.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- I  input  WIDTH  operand to shift.
- S  input  SW  shift amount, 0..WIDTH-1, unsigned.
- R  input  1  direction: 1 = logical right shift, 0 = logical left shift.
- O  output  WIDTH  registered shift result.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Operation: logical shifts only, zero fill.
  - R=1: O = I >> S.
  - R=0: O = I << S.
  - No rotation, no sign extension.
- Stage k (k = 0..SW-1):
  - Input is the previous stage's data; stage 0 takes I directly.
  - Shifts its input by 2**k in the carried direction if the carried S[k] is 1; otherwise passes it unchanged.
  - Registers the result.
- Each stage also registers the R bit and the not-yet-consumed upper S bits, so every in-flight operation keeps its own shift amount and direction.
- O is driven directly from the stage SW-1 data register; no combinational path from inputs to O.
- Latency:
  - Inputs sampled at rising edge n appear on O after rising edge n+4, i.e. 5 register stages.
  - O holds that value until edge n+5.
- Throughput: one operation per cycle; no handshake, stall or valid signal.
  - Inputs are sampled every cycle.
  - The environment must hold I, S and R at defined values whenever results are consumed.
- Reset, on a rising edge with reset=1:
  - Clears every pipeline register (data, carried S bits, carried R) to 0.
  - O = 0 from that edge on while reset stays high.
  - In-flight operations are discarded, including on reset mid-stream.
  - Inputs are ignored while reset=1.
- After reset deasserts:
  - The first sampling edge is the first rising edge with reset=0.
  - O stays 0 until that operation's result emerges 5 edges later.
- Boundaries:
  - S=0 gives O=I.
  - S=31 moves one bit end to end.
  - Bits shifted out are lost.
  - Results are exact modulo WIDTH bits; no overflow flag.
- Back-to-back operations with different S/R must not interfere; each result depends only on its own sampled inputs.

Test Plan:
- reset=1 for 2 edges, then 0; I=10, R=1, S=2 at the next edge -> O=2 exactly 5 edges later; O=0 before that.
- I=63, R=0, S=5 on the cycle after the previous op -> O=0x000007E0 one cycle after the previous result (back-to-back, no interference).
- S=0 with I=0xDEADBEEF, R=0 and again with R=1 -> O=0xDEADBEEF both times.
- Extreme shifts:
  - I=0x80000000, R=1, S=31 -> O=0x00000001.
  - I=0x00000001, R=0, S=31 -> O=0x80000000.
  - I=0xFFFFFFFF, R=1, S=16 -> O=0x0000FFFF (zero fill).
- Stream of 5 different ops, then reset=1 for one edge in mid-stream -> O=0 immediately after that edge; no pre-reset results ever appear.
- Random I/S/R every cycle for 1000 cycles -> O equals the software model of the inputs sampled 5 edges earlier.
